int_ctrl: RTL and testbench

Memory-mapped interrupt controller between the peripheral block (UART receiver, future timer/GPIO) and the MIPS core's single int0 input.
- Latches rising edges from up to N_SRC sources into a pending register.
- Applies a software mask.
- Arbitrates by fixed priority; index 0 is highest.
- Sequences each interrupt through a request/acknowledge/end-of-interrupt handshake with the core. No nesting.

---
 rtl/int_ctrl.sv | 136 +++++++++++++
 tb/tb_int_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/int_ctrl.sv
// Interrupt controller: edge-latched pending bits, software mask, fixed-priority
// arbitration and a req/ack/eoi handshake toward the core's int0 input.
module int_ctrl #(
    parameter int unsigned N_SRC = 4,
    parameter int unsigned VEC_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_src,
    input  logic             bus_we,
    input  logic [1:0]       bus_addr,
    input  logic [31:0]      bus_wdata,
    output logic [31:0]      bus_rdata,
    output logic             int0,
    output logic [VEC_W-1:0] int_vec,
    input  logic             int_ack,
    input  logic             int_eoi
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_e;

    localparam logic [1:0] ADDR_PENDING = 2'd0;
    localparam logic [1:0] ADDR_MASK    = 2'd1;
    localparam logic [1:0] ADDR_STATUS  = 2'd2;
    localparam logic [1:0] ADDR_SWTRIG  = 2'd3;

    state_e             state_q;
    logic               int0_q;
    logic [VEC_W-1:0]   int_vec_q;
    logic [N_SRC-1:0]   src_q;
    logic [N_SRC-1:0]   pending_q, pending_d;
    logic [N_SRC-1:0]   mask_q, mask_d;

    logic [N_SRC-1:0]   rise;
    logic [N_SRC-1:0]   w1c;
    logic [N_SRC-1:0]   swtrig;
    logic [N_SRC-1:0]   elig;
    logic [N_SRC-1:0]   vec_oh;
    logic [N_SRC-1:0]   ack_clr;
    logic               req_live;
    logic               ack_take;
    logic [VEC_W-1:0]   first_vec;
    logic [31:0]        status;
    logic               unused_wdata;

    assign unused_wdata = ^bus_wdata;

    // Event sources, eligibility and pending-register next state (set wins over clear)
    always_comb begin
        rise      = irq_src & ~src_q;
        w1c       = (bus_we && bus_addr == ADDR_PENDING) ? bus_wdata[N_SRC-1:0] : '0;
        swtrig    = (bus_we && bus_addr == ADDR_SWTRIG)  ? bus_wdata[N_SRC-1:0] : '0;
        mask_d    = (bus_we && bus_addr == ADDR_MASK)    ? bus_wdata[N_SRC-1:0] : mask_q;
        elig      = pending_q & mask_q;
        vec_oh    = N_SRC'(1) << int_vec_q;
        req_live  = |(elig & vec_oh);
        ack_take  = (state_q == REQ) && req_live && int_ack;
        ack_clr   = ack_take ? vec_oh : '0;
        pending_d = (pending_q & ~(w1c | ack_clr)) | rise | swtrig;
    end

    // Lowest eligible index has the highest priority
    always_comb begin
        first_vec = '0;
        for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
            if (elig[i]) first_vec = VEC_W'(i);
        end
    end

    always_comb begin
        status              = '0;
        status[9:8]         = state_q;
        status[VEC_W-1:0]   = int_vec_q;
        unique case (bus_addr)
            ADDR_PENDING: bus_rdata = 32'(pending_q);
            ADDR_MASK:    bus_rdata = 32'(mask_q);
            ADDR_STATUS:  bus_rdata = status;
            default:      bus_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q     <= '0;
            pending_q <= '0;
            mask_q    <= '0;
        end else begin
            src_q     <= irq_src;
            pending_q <= pending_d;
            mask_q    <= mask_d;
        end
    end

    // Handshake sequencer; a request withdrawn by W1C or masking takes precedence over ack
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            int0_q    <= 1'b0;
            int_vec_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (|elig) begin
                        int_vec_q <= first_vec;
                        int0_q    <= 1'b1;
                        state_q   <= REQ;
                    end
                end
                REQ: begin
                    if (!req_live) begin
                        int0_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (int_ack) begin
                        int0_q  <= 1'b0;
                        state_q <= SERVICE;
                    end
                end
                SERVICE: begin
                    if (int_eoi) state_q <= IDLE;
                end
                default: begin
                    int0_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign int0    = int0_q;
    assign int_vec = int_vec_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed vector table, hand-written reset/level sequences,
// and randomized traffic checked against a behavioural model.
module tb_int_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  irq_src;
    logic        bus_we;
    logic [1:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        int0;
    logic [1:0]  int_vec;
    logic        int_ack;
    logic        int_eoi;

    int_ctrl #(.N_SRC(4), .VEC_W(2)) dut (
        .clk(clk), .rst(rst), .irq_src(irq_src), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .int0(int0), .int_vec(int_vec), .int_ack(int_ack), .int_eoi(int_eoi)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic        s_int0;
    logic [1:0]  s_vec;
    logic [31:0] s_rdata;

    typedef struct {
        logic [3:0]  irq;
        logic        we;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic        ack;
        logic        eoi;
        logic        e_int0;
        logic [1:0]  e_vec;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t tbl[$];

    // Behavioural model: pending/mask as bit sets, handshake phase as an integer
    bit [3:0] m_pend, m_mask, m_src;
    int       m_phase;   // 0 waiting, 1 requesting, 2 in handler
    bit       m_int0;
    int       m_vec;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = '0; m_mask = '0; m_src = '0;
        m_phase = 0; m_int0 = 1'b0; m_vec = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] addr);
        case (addr)
            2'd0:    return {28'd0, m_pend};
            2'd1:    return {28'd0, m_mask};
            2'd2:    return (m_phase * 256) + m_vec;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step(input logic [3:0] irq, input logic we, input logic [1:0] addr,
                              input logic [31:0] wd, input logic ack, input logic eoi);
        bit [3:0] ok;
        bit [3:0] nxt;
        ok  = m_pend & m_mask;
        nxt = m_pend;
        if (we && addr == 2'd0) nxt = nxt & ~wd[3:0];
        if (m_phase == 0) begin
            if (ok != 0) begin
                for (int i = 3; i >= 0; i--) if (ok[i]) m_vec = i;
                m_int0 = 1'b1; m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (!ok[m_vec]) begin
                m_int0 = 1'b0; m_phase = 0;
            end else if (ack) begin
                nxt[m_vec] = 1'b0; m_int0 = 1'b0; m_phase = 2;
            end
        end else begin
            if (eoi) m_phase = 0;
        end
        for (int i = 0; i < 4; i++) begin
            if (irq[i] && !m_src[i]) nxt[i] = 1'b1;
            if (we && addr == 2'd3 && wd[i]) nxt[i] = 1'b1;
        end
        if (we && addr == 2'd1) m_mask = wd[3:0];
        m_src  = irq;
        m_pend = nxt;
    endtask

    task automatic cyc(input logic [3:0] irq, input logic we, input logic [1:0] addr,
                       input logic [31:0] wd, input logic ack, input logic eoi);
        irq_src = irq; bus_we = we; bus_addr = addr; bus_wdata = wd;
        int_ack = ack; int_eoi = eoi;
        @(posedge clk);
        #1;
        s_int0 = int0; s_vec = int_vec; s_rdata = bus_rdata;
        @(negedge clk);
    endtask

    task automatic do_reset();
        irq_src = '0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
        int_ack = 1'b0; int_eoi = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic add(input logic [3:0] irq, input logic we, input logic [1:0] addr,
                       input logic [31:0] wd, input logic ack, input logic eoi,
                       input logic e0, input logic [1:0] ev, input logic [31:0] er);
        vec_t v;
        v.irq = irq; v.we = we; v.addr = addr; v.wdata = wd; v.ack = ack; v.eoi = eoi;
        v.e_int0 = e0; v.e_vec = ev; v.e_rdata = er;
        tbl.push_back(v);
    endtask

    initial begin
        int rises;
        logic prev;

        // irq   we    addr   wdata          ack  eoi   int0 vec  rdata
        add(4'h0, 1'b1, 2'd1, 32'h1,         1'b0, 1'b0, 1'b0, 2'd0, 32'h1);
        add(4'h1, 1'b0, 2'd0, 32'h0,         1'b0, 1'b0, 1'b0, 2'd0, 32'h1);
        add(4'h0, 1'b0, 2'd0, 32'h0,         1'b0, 1'b0, 1'b1, 2'd0, 32'h1);
        add(4'h0, 1'b0, 2'd0, 32'h0,         1'b1, 1'b0, 1'b0, 2'd0, 32'h0);
        add(4'h0, 1'b0, 2'd2, 32'h0,         1'b0, 1'b0, 1'b0, 2'd0, 32'h200);
        add(4'h0, 1'b0, 2'd2, 32'h0,         1'b0, 1'b1, 1'b0, 2'd0, 32'h0);
        add(4'h0, 1'b0, 2'd2, 32'h0,         1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
        add(4'h0, 1'b1, 2'd1, 32'hF,         1'b0, 1'b0, 1'b0, 2'd0, 32'hF);
        add(4'h6, 1'b0, 2'd0, 32'h0,         1'b0, 1'b0, 1'b0, 2'd0, 32'h6);
        add(4'h6, 1'b0, 2'd0, 32'h0,         1'b0, 1'b0, 1'b1, 2'd1, 32'h6);
        add(4'h6, 1'b0, 2'd0, 32'h0,         1'b1, 1'b0, 1'b0, 2'd1, 32'h4);
        add(4'h0, 1'b0, 2'd2, 32'h0,         1'b0, 1'b1, 1'b0, 2'd1, 32'h1);
        add(4'h0, 1'b0, 2'd2, 32'h0,         1'b0, 1'b0, 1'b1, 2'd2, 32'h102);
        add(4'h0, 1'b0, 2'd0, 32'h0,         1'b1, 1'b0, 1'b0, 2'd2, 32'h0);
        add(4'h0, 1'b0, 2'd2, 32'h0,         1'b0, 1'b1, 1'b0, 2'd2, 32'h2);
        add(4'h8, 1'b0, 2'd0, 32'h0,         1'b0, 1'b0, 1'b0, 2'd2, 32'h8);
        add(4'h0, 1'b0, 2'd0, 32'h0,         1'b0, 1'b0, 1'b1, 2'd3, 32'h8);
        add(4'h1, 1'b0, 2'd0, 32'h0,         1'b0, 1'b0, 1'b1, 2'd3, 32'h9);
        add(4'h0, 1'b0, 2'd0, 32'h0,         1'b0, 1'b0, 1'b1, 2'd3, 32'h9);
        add(4'h0, 1'b0, 2'd0, 32'h0,         1'b1, 1'b0, 1'b0, 2'd3, 32'h1);
        add(4'h0, 1'b0, 2'd2, 32'h0,         1'b0, 1'b1, 1'b0, 2'd3, 32'h3);
        add(4'h0, 1'b0, 2'd2, 32'h0,         1'b0, 1'b0, 1'b1, 2'd0, 32'h100);
        add(4'h0, 1'b0, 2'd0, 32'h0,         1'b1, 1'b0, 1'b0, 2'd0, 32'h0);
        add(4'h0, 1'b0, 2'd2, 32'h0,         1'b0, 1'b1, 1'b0, 2'd0, 32'h0);
        add(4'h0, 1'b1, 2'd1, 32'h0,         1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
        add(4'h2, 1'b0, 2'd0, 32'h0,         1'b0, 1'b0, 1'b0, 2'd0, 32'h2);
        add(4'h0, 1'b0, 2'd0, 32'h0,         1'b0, 1'b0, 1'b0, 2'd0, 32'h2);
        add(4'h0, 1'b0, 2'd0, 32'h0,         1'b0, 1'b0, 1'b0, 2'd0, 32'h2);
        add(4'h0, 1'b1, 2'd1, 32'h2,         1'b0, 1'b0, 1'b0, 2'd0, 32'h2);
        add(4'h0, 1'b0, 2'd0, 32'h0,         1'b0, 1'b0, 1'b1, 2'd1, 32'h2);
        add(4'h0, 1'b1, 2'd0, 32'h2,         1'b0, 1'b0, 1'b1, 2'd1, 32'h0);
        add(4'h0, 1'b0, 2'd2, 32'h0,         1'b0, 1'b0, 1'b0, 2'd1, 32'h1);
        add(4'h0, 1'b1, 2'd1, 32'h4,         1'b0, 1'b0, 1'b0, 2'd1, 32'h4);
        add(4'h0, 1'b1, 2'd3, 32'h4,         1'b0, 1'b0, 1'b0, 2'd1, 32'h0);
        add(4'h0, 1'b0, 2'd0, 32'h0,         1'b0, 1'b0, 1'b1, 2'd2, 32'h4);
        add(4'h0, 1'b0, 2'd2, 32'h0,         1'b1, 1'b1, 1'b0, 2'd2, 32'h202);
        add(4'h0, 1'b0, 2'd0, 32'h0,         1'b0, 1'b1, 1'b0, 2'd2, 32'h0);
        add(4'h0, 1'b1, 2'd2, 32'hFFFFFFFF,  1'b0, 1'b0, 1'b0, 2'd2, 32'h2);
        add(4'h0, 1'b0, 2'd1, 32'h0,         1'b1, 1'b1, 1'b0, 2'd2, 32'h4);
        add(4'h0, 1'b1, 2'd1, 32'hFFFFFFF1,  1'b0, 1'b0, 1'b0, 2'd2, 32'h1);

        do_reset();
        // Reset state, every register readable through the combinational mux
        for (int a = 0; a < 4; a++) begin
            bus_addr = 2'(a);
            #1;
            chk($sformatf("reset_rdata%0d", a), bus_rdata, 32'h0);
        end
        chk("reset_int0", 32'(int0), 32'h0);
        chk("reset_vec", 32'(int_vec), 32'h0);
        @(negedge clk);

        foreach (tbl[i]) begin
            cyc(tbl[i].irq, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].ack, tbl[i].eoi);
            chk($sformatf("tbl%0d_int0", i), 32'(s_int0), 32'(tbl[i].e_int0));
            chk($sformatf("tbl%0d_vec", i), 32'(s_vec), 32'(tbl[i].e_vec));
            chk($sformatf("tbl%0d_rdata", i), s_rdata, tbl[i].e_rdata);
        end

        // Level held high for many cycles yields a single request; core acks whenever int0 is seen
        rises = 0; prev = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cyc(4'h1, 1'b0, 2'd2, 32'h0, int0, 1'b0);
            if (s_int0 && !prev) rises++;
            prev = s_int0;
        end
        chk("level_one_event", 32'(rises), 32'd1);
        chk("level_in_service", s_rdata, 32'h200);
        cyc(4'h0, 1'b1, 2'd1, 32'hF, 1'b0, 1'b0);
        cyc(4'h0, 1'b1, 2'd3, 32'h6, 1'b0, 1'b0);
        cyc(4'h0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
        chk("svc_pend_before_rst", s_rdata, 32'h6);

        // Async reset mid-service: everything clears without waiting for an edge
        #2 rst = 1'b1;
        for (int a = 0; a < 3; a++) begin
            bus_addr = 2'(a);
            #1;
            chk($sformatf("async_rst_rdata%0d", a), bus_rdata, 32'h0);
        end
        chk("async_rst_int0", 32'(int0), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Async reset while int0 is asserted
        cyc(4'h0, 1'b1, 2'd1, 32'h8, 1'b0, 1'b0);
        cyc(4'h8, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
        cyc(4'h0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
        chk("req_before_rst", 32'(s_int0), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_req_int0", 32'(int0), 32'h0);
        chk("async_rst_req_vec", 32'(int_vec), 32'h0);

        // Randomized traffic against the behavioural model
        do_reset();
        model_reset();
        for (int n = 0; n < 600; n++) begin
            logic [3:0]  r_irq;
            logic        r_we, r_ack, r_eoi;
            logic [1:0]  r_addr;
            logic [31:0] r_wd;
            r_irq  = 4'($urandom_range(0, 15));
            r_we   = ($urandom_range(0, 5) == 0);
            r_addr = 2'($urandom_range(0, 3));
            r_wd   = $urandom;
            r_ack  = ($urandom_range(0, 2) == 0);
            r_eoi  = ($urandom_range(0, 3) == 0);
            model_step(r_irq, r_we, r_addr, r_wd, r_ack, r_eoi);
            cyc(r_irq, r_we, r_addr, r_wd, r_ack, r_eoi);
            chk($sformatf("rnd%0d_int0", n), 32'(s_int0), 32'(m_int0));
            chk($sformatf("rnd%0d_vec", n), 32'(s_vec), 32'(m_vec));
            chk($sformatf("rnd%0d_rdata", n), s_rdata, model_read(r_addr));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
